// File: rtl/digit_display_ctrl_pkg.sv
// rtl/digit_display_ctrl_pkg.sv - shared sizing, glyph geometry and FSM state type for the digit display
package digit_display_ctrl_pkg;

  localparam int DIGITS  = 4;
  localparam int VAL_W   = 14;
  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // Largest value representable in the given number of decimal digits.
  function automatic int max_value(input int digits);
    int r;
    r = 1;
    for (int i = 0; i < digits; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

endpackage

// File: rtl/digit_display_ctrl_bin2bcd_seq.sv
// rtl/digit_display_ctrl_bin2bcd_seq.sv - sequential double-dabble converter, one input bit per cycle
module bin2bcd_seq #(
  parameter int DIGITS = digit_display_ctrl_pkg::DIGITS,
  parameter int VAL_W  = digit_display_ctrl_pkg::VAL_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [VAL_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int CNT_W = $clog2(VAL_W + 1);

  logic [VAL_W-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                active_q, active_d;

  // done marks the cycle in which the final bit is shifted in
  assign done = active_q && (cnt_q == CNT_W'(VAL_W - 1));
  assign bcd  = bcd_q;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      bin_d    = bin;
      bcd_d    = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      bcd_d = {adj[4*DIGITS-2:0], bin_q[VAL_W-1]};
      bin_d = bin_q << 1;
      cnt_d = cnt_q + 1'b1;
      if (done) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/digit_display_ctrl.sv
// rtl/digit_display_ctrl.sv - converts a binary value to BCD digits and serves them to a VGA glyph renderer
module digit_display_ctrl
  import digit_display_ctrl_pkg::*;
#(
  parameter int DIGITS = digit_display_ctrl_pkg::DIGITS,
  parameter int VAL_W  = digit_display_ctrl_pkg::VAL_W
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [VAL_W-1:0] value,
  input  logic             load,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic [9:0]       originX,
  input  logic [9:0]       originY,
  output logic [9:0]       relativeXF,
  output logic [9:0]       relativeYF,
  output logic [3:0]       number,
  output logic             in_field,
  output logic             busy,
  output logic             done
);

  localparam int               MAX_VAL = max_value(DIGITS);
  localparam logic [VAL_W-1:0] MAX_V   = VAL_W'(MAX_VAL);

  state_e              state_q, state_d;
  logic                pending_q, pending_d;
  logic [VAL_W-1:0]    val_q, val_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic                done_q, done_d;
  logic                start, commit;
  logic [VAL_W-1:0]    start_val, sat_val;
  logic [4*DIGITS-1:0] conv_bcd;
  logic                conv_done;

  logic [10:0] x_end, y_end;
  logic [9:0]  rel_x, rel_y, col;
  logic        in_field_d;
  logic [9:0]  rel_x_d, rel_y_d;
  logic [3:0]  number_d;
  logic [9:0]  rel_x_q, rel_y_q;
  logic [3:0]  number_q;
  logic        in_field_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load || pending_q) state_d = SHIFT;
      SHIFT:   if (conv_done) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start  = (state_q == IDLE) && (load || pending_q);
    commit = (state_q == COMMIT);
    busy   = (state_q != IDLE);
  end

  // A fresh load in IDLE wins over a pending one since it is the latest value.
  always_comb begin
    start_val = load ? value : val_q;
    sat_val   = (start_val > MAX_V) ? MAX_V : start_val;
    val_d     = load ? value : val_q;
    pending_d = pending_q;
    if (start) begin
      pending_d = 1'b0;
    end
    if (load && (state_q != IDLE)) begin
      pending_d = 1'b1;
    end
    digits_d = commit ? conv_bcd : digits_q;
    done_d   = commit;
  end

  bin2bcd_seq #(
    .DIGITS (DIGITS),
    .VAL_W  (VAL_W)
  ) u_bin2bcd (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .start (start),
    .bin   (sat_val),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  // Field bounds are widened to 11 bits so a field near the right edge never wraps.
  always_comb begin
    x_end      = {1'b0, originX} + 11'(GLYPH_W * DIGITS);
    y_end      = {1'b0, originY} + 11'(GLYPH_H);
    in_field_d = (DrawX >= originX) && ({1'b0, DrawX} < x_end) &&
                 (DrawY >= originY) && ({1'b0, DrawY} < y_end);
    rel_x      = DrawX - originX;
    rel_y      = DrawY - originY;
    col        = rel_x / 10'(GLYPH_W);
    rel_x_d    = in_field_d ? rel_x : 10'd0;
    rel_y_d    = in_field_d ? rel_y : 10'd0;
    number_d   = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (in_field_d && (col == 10'(DIGITS - 1 - i))) begin
        number_d = digits_q[4*i +: 4];
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= 1'b0;
      val_q      <= '0;
      digits_q   <= '0;
      done_q     <= 1'b0;
      rel_x_q    <= '0;
      rel_y_q    <= '0;
      number_q   <= '0;
      in_field_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      val_q      <= val_d;
      digits_q   <= digits_d;
      done_q     <= done_d;
      rel_x_q    <= rel_x_d;
      rel_y_q    <= rel_y_d;
      number_q   <= number_d;
      in_field_q <= in_field_d;
    end
  end

  assign relativeXF = rel_x_q;
  assign relativeYF = rel_y_q;
  assign number     = number_q;
  assign in_field   = in_field_q;
  assign done       = done_q;

endmodule

// File: tb/tb_digit_display_ctrl.sv
// tb/tb_digit_display_ctrl.sv - randomized scoreboard bench for digit_display_ctrl
module tb_digit_display_ctrl;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] value = '0;
  logic        load = 1'b0;
  logic [9:0]  DrawX = 10'd100, DrawY = 10'd50, originX = 10'd100, originY = 10'd50;
  logic [9:0]  relativeXF, relativeYF;
  logic [3:0]  number;
  logic        in_field, busy, done;

  always #5 vga_clk = ~vga_clk;

  digit_display_ctrl dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .value      (value),
    .load       (load),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .originX    (originX),
    .originY    (originY),
    .relativeXF (relativeXF),
    .relativeYF (relativeYF),
    .number     (number),
    .in_field   (in_field),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    int val;
    int edge_n;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  bit   busy_exp [0:4095];
  bit   pend = 0;
  int   pend_val = 0;
  int   disp_val = 0;
  bit   px_rand = 1;
  int   sx, sy, sox, soy;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int p10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Reference: a load at an idle edge starts a 15-edge conversion; loads during it collapse into one pending value.
  task automatic model_edge(input int e, input bit l, input int v);
    bit busy_now;
    int sv;
    busy_now = (e > 0) && busy_exp[e-1];
    if (busy_now) begin
      if (l) begin
        pend     = 1;
        pend_val = v;
      end
    end else if (l || pend) begin
      sv   = l ? v : pend_val;
      sv   = (sv > 9999) ? 9999 : sv;
      pend = 0;
      for (int i = 0; i < 15; i++) busy_exp[e+i] = 1;
      exp_q.push_back('{sv, e + 15});
    end
  endtask

  task automatic tick(input bit l, input int v);
    load  = l;
    value = 14'(v);
    model_edge(cyc + 1, l, v);
    @(negedge vga_clk);
    load = 1'b0;
  endtask

  always @(posedge vga_clk) begin
    cyc++;
    sx  = int'(DrawX);
    sy  = int'(DrawY);
    sox = int'(originX);
    soy = int'(originY);
  end

  always @(negedge vga_clk) begin
    if (px_rand) begin
      if ($urandom_range(0, 15) == 0) begin
        originX = 10'($urandom_range(0, 1023));
        originY = 10'($urandom_range(0, 1023));
      end
      DrawX = originX + 10'($urandom_range(0, 40)) - 10'd4;
      DrawY = originY + 10'($urandom_range(0, 20)) - 10'd2;
    end
  end

  // Monitor: pixel outputs use the display as committed before this edge, then done updates it.
  always @(negedge vga_clk) begin
    bit   inf;
    int   ex_num;
    exp_t ex;
    if (reset_n) begin
      inf    = (sx >= sox) && (sx < sox + 32) && (sy >= soy) && (sy < soy + 16);
      ex_num = inf ? (disp_val / p10(3 - (sx - sox) / 8)) % 10 : 0;
      chk("px_in_field", int'(in_field), int'(inf));
      chk("px_relativeXF", int'(relativeXF), inf ? sx - sox : 0);
      chk("px_relativeYF", int'(relativeYF), inf ? sy - soy : 0);
      chk("px_number", int'(number), ex_num);
      chk("busy", int'(busy), int'(busy_exp[cyc]));
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          ex = exp_q.pop_front();
          chk("done_edge", cyc, ex.edge_n);
          disp_val = ex.val;
        end
      end else if (exp_q.size() != 0 && exp_q[0].edge_n <= cyc) begin
        ex = exp_q.pop_front();
        chk("done_missing", 0, 1);
        disp_val = ex.val;
      end
    end
  end

  task automatic check_all_zero(input string name);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(done), 0);
    chk({name, "_in_field"}, int'(in_field), 0);
    chk({name, "_number"}, int'(number), 0);
    chk({name, "_relXF"}, int'(relativeXF), 0);
    chk({name, "_relYF"}, int'(relativeYF), 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) busy_exp[i] = 0;
    repeat (3) @(negedge vga_clk);
    check_all_zero("reset");
    #1 reset_n = 1'b1;

    tick(1, 1234);
    repeat (20) tick(0, 0);
    tick(1, 16383);
    repeat (20) tick(0, 0);
    tick(1, 500);
    repeat (4) tick(0, 0);
    tick(1, 42);
    repeat (40) tick(0, 0);

    tick(1, 739);
    repeat (18) tick(0, 0);
    px_rand = 0;
    originX = 10'd100; originY = 10'd50; DrawX = 10'd117; DrawY = 10'd55;
    tick(0, 0);
    chk("field_in_field", int'(in_field), 1);
    chk("field_relXF", int'(relativeXF), 17);
    chk("field_relYF", int'(relativeYF), 5);
    chk("field_number", int'(number), 3);
    DrawX = 10'd132;
    tick(0, 0);
    chk("right_edge_in_field", int'(in_field), 0);
    chk("right_edge_number", int'(number), 0);
    DrawX = 10'd117; DrawY = 10'd66;
    tick(0, 0);
    chk("bottom_edge_in_field", int'(in_field), 0);
    chk("bottom_edge_relXF", int'(relativeXF), 0);
    px_rand = 1;

    tick(1, 1234);
    repeat (18) tick(0, 0);
    tick(1, 5678);
    repeat (5) tick(0, 0);
    @(posedge vga_clk);
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    exp_q.delete();
    pend     = 0;
    disp_val = 0;
    for (int i = 0; i < 4096; i++) busy_exp[i] = 0;
    repeat (2) @(negedge vga_clk);
    #1 reset_n = 1'b1;
    tick(1, 77);
    repeat (18) tick(0, 0);

    repeat (600) begin
      if ($urandom_range(0, 9) == 0) tick(1, int'($urandom_range(0, 16383)));
      else tick(0, 0);
    end
    repeat (40) tick(0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
